// File: rtl/clock_pkg.sv
// Shared definitions for the front-panel time/alarm set sequencer:
// edit-state encodings, blink digit positions and default timing parameters.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_ALM_HR  = 3'd3,
    ST_ALM_MIN = 3'd4
  } edit_state_e;

  localparam int DIG_MIN     = 0;
  localparam int DIG_MIN_TEN = 1;
  localparam int DIG_HR      = 2;
  localparam int DIG_HR_TEN  = 3;

  localparam int DEF_DWL           = 8;
  localparam int DEF_REPEAT_DELAY  = 50_000_000;
  localparam int DEF_REPEAT_PERIOD = 10_000_000;
  localparam int DEF_TIMEOUT       = 500_000_000;
  localparam int DEF_BLINK_HALF    = 25_000_000;

  function automatic logic is_edit_state(edit_state_e s);
    return (s == ST_SET_HR) || (s == ST_SET_MIN) ||
           (s == ST_ALM_HR) || (s == ST_ALM_MIN);
  endfunction

  function automatic logic is_hour_state(edit_state_e s);
    return (s == ST_SET_HR) || (s == ST_ALM_HR);
  endfunction

  function automatic logic is_min_state(edit_state_e s);
    return (s == ST_SET_MIN) || (s == ST_ALM_MIN);
  endfunction

  // MODE walks the ring; anything unrecognised lands back in RUN.
  function automatic edit_state_e next_mode_state(edit_state_e s);
    case (s)
      ST_RUN:     return ST_SET_HR;
      ST_SET_HR:  return ST_SET_MIN;
      ST_SET_MIN: return ST_ALM_HR;
      ST_ALM_HR:  return ST_ALM_MIN;
      default:    return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Button inputs and clock-system/display outputs of the time set sequencer.
// The slave side is the controller; the master side drives the buttons.
interface time_set_controller_if #(
  parameter int DWL = 8
);
  logic           ModeBtn;
  logic           UpBtn;
  logic           MinInc;
  logic           HourInc;
  logic           AlarmSel;
  logic           ClockHold;
  logic [DWL-5:0] BlinkMask;
  logic [2:0]     EditState;

  modport master (
    output ModeBtn, UpBtn,
    input  MinInc, HourInc, AlarmSel, ClockHold, BlinkMask, EditState
  );

  modport slave (
    input  ModeBtn, UpBtn,
    output MinInc, HourInc, AlarmSel, ClockHold, BlinkMask, EditState
  );
endinterface

// File: rtl/button_repeater.sv
// Rising-edge detector with hold-to-repeat: one strobe on press, then after
// REPEAT_DELAY cycles of holding, one strobe every REPEAT_PERIOD cycles.
module button_repeater
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic edge_o,
  output logic strobe_o
);

  localparam int CW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] CNT_FIRE   = CW'(REPEAT_DELAY);
  // Reloading here puts the next fire exactly REPEAT_PERIOD cycles later.
  localparam logic [CW-1:0] CNT_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic          level_prev_q;
  logic          lock_q, lock_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active;
  logic          fire_edge;
  logic          fire_repeat;

  assign active      = enable_i & ~clear_i;
  assign fire_edge   = level_i & ~level_prev_q & ~lock_q & active;
  assign fire_repeat = level_i & active & (cnt_q == CNT_FIRE);
  assign edge_o      = fire_edge;
  assign strobe_o    = fire_edge | fire_repeat;

  always_comb begin
    cnt_d  = cnt_q;
    lock_d = lock_q;

    // A press that was cleared or arrived while disabled stays dead until release.
    if ((clear_i | ~enable_i) & level_i) begin
      lock_d = 1'b1;
    end else if (!level_i) begin
      lock_d = 1'b0;
    end

    if (!active || !level_i) begin
      cnt_d = '0;
    end else if (fire_edge) begin
      cnt_d = CW'(1);
    end else if (cnt_q == CNT_FIRE) begin
      cnt_d = CNT_RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev_q <= 1'b0;
      lock_q       <= 1'b1;
      cnt_q        <= '0;
    end else begin
      level_prev_q <= level_i;
      lock_q       <= lock_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Front-panel edit sequencer: MODE steps RUN/SET/ALARM states, UP issues
// minute/hour increment strobes, with blink mask and idle timeout.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int DWL           = DEF_DWL,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int BLINK_HALF    = DEF_BLINK_HALF
) (
  input  logic                  CLK,
  input  logic                  CLR,
  time_set_controller_if.slave  bus
);

  localparam int MW = DWL - 4;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  edit_state_e   state_q, state_d;
  logic          mode_prev_q;
  logic          mode_armed_q;
  logic          mode_edge;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          min_inc_q, min_inc_d;
  logic          hour_inc_q, hour_inc_d;
  logic          alarm_sel_q, alarm_sel_d;
  logic          clock_hold_q, clock_hold_d;
  logic [MW-1:0] mask_q, mask_d;
  logic [MW-1:0] hour_digits;
  logic [MW-1:0] min_digits;
  logic          edit_active;
  logic          up_edge;
  logic          up_strobe;

  // MODE held through reset release must be seen low before it can count.
  assign mode_edge   = bus.ModeBtn & ~mode_prev_q & mode_armed_q;
  assign edit_active = is_edit_state(state_q);

  for (genvar gi = 0; gi < MW; gi++) begin : g_digit
    assign hour_digits[gi] = (gi == DIG_HR)  || (gi == DIG_HR_TEN);
    assign min_digits[gi]  = (gi == DIG_MIN) || (gi == DIG_MIN_TEN);
  end

  button_repeater #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_up_repeater (
    .clk      (CLK),
    .rst      (CLR),
    .level_i  (bus.UpBtn),
    .enable_i (edit_active),
    .clear_i  (mode_edge),
    .edge_o   (up_edge),
    .strobe_o (up_strobe)
  );

  always_comb begin
    state_d      = state_q;
    idle_d       = idle_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    mask_d       = '0;
    min_inc_d    = 1'b0;
    hour_inc_d   = 1'b0;
    alarm_sel_d  = 1'b0;
    clock_hold_d = 1'b0;

    if (mode_edge || !is_edit_state(state_q)) begin
      state_d = next_mode_state(state_q);
      if (!mode_edge && (state_q == ST_RUN)) begin
        state_d = ST_RUN;
      end
    end

    if (!edit_active || mode_edge || up_edge || bus.UpBtn) begin
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      idle_d  = '0;
      state_d = ST_RUN;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    if (state_d != state_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    // Blanking is suppressed while UP is held so the value being edited stays visible.
    if (phase_d && !bus.UpBtn) begin
      if (is_hour_state(state_d)) begin
        mask_d = hour_digits;
      end else if (is_min_state(state_d)) begin
        mask_d = min_digits;
      end
    end

    hour_inc_d   = up_strobe & is_hour_state(state_q);
    min_inc_d    = up_strobe & is_min_state(state_q);
    alarm_sel_d  = (state_d == ST_ALM_HR) || (state_d == ST_ALM_MIN);
    clock_hold_d = (state_d == ST_SET_HR) || (state_d == ST_SET_MIN);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q      <= ST_RUN;
      mode_prev_q  <= 1'b0;
      mode_armed_q <= 1'b0;
      idle_q       <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      mask_q       <= '0;
      min_inc_q    <= 1'b0;
      hour_inc_q   <= 1'b0;
      alarm_sel_q  <= 1'b0;
      clock_hold_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_prev_q  <= bus.ModeBtn;
      mode_armed_q <= mode_armed_q | ~bus.ModeBtn;
      idle_q       <= idle_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      mask_q       <= mask_d;
      min_inc_q    <= min_inc_d;
      hour_inc_q   <= hour_inc_d;
      alarm_sel_q  <= alarm_sel_d;
      clock_hold_q <= clock_hold_d;
    end
  end

  assign bus.MinInc    = min_inc_q;
  assign bus.HourInc   = hour_inc_q;
  assign bus.AlarmSel  = alarm_sel_q;
  assign bus.ClockHold = clock_hold_q;
  assign bus.BlinkMask = mask_q;
  assign bus.EditState = state_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with a cycle-level behavioural model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_time_set_controller;

  localparam int RD = 8;
  localparam int RP = 4;
  localparam int TO = 32;
  localparam int BH = 4;

  logic clk = 1'b0;
  logic CLR = 1'b1;
  always #5 clk = ~clk;

  time_set_controller_if #(.DWL(8)) bus ();

  time_set_controller #(
    .DWL           (8),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .TIMEOUT       (TO),
    .BLINK_HALF    (BH)
  ) dut (
    .CLK (clk),
    .CLR (CLR),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, want, $time);
    end
  endtask

  // Behavioural model: state number, press time, last activity time, last state change.
  int m_cyc = 0, m_state = 0, m_tpress = 0, m_tchange = 0, m_lastact = 0;
  bit m_pvalid = 0, m_mprev = 0, m_uprev = 0, m_mlow = 0, m_ulow = 0;
  int exp_state = 0, exp_mask = 0;
  bit exp_min = 0, exp_hour = 0, exp_alm = 0, exp_hold = 0;

  always @(posedge clk or posedge CLR) begin : model_p
    int t, d, ns, tp, tc, la;
    bit mr, ur, ed, pv, strobe, ph;
    if (CLR) begin
      m_cyc <= 0; m_state <= 0; m_tpress <= 0; m_tchange <= 0; m_lastact <= 0;
      m_pvalid <= 0; m_mprev <= 0; m_uprev <= 0; m_mlow <= 0; m_ulow <= 0;
      exp_state <= 0; exp_mask <= 0; exp_min <= 0; exp_hour <= 0;
      exp_alm <= 0; exp_hold <= 0;
    end else begin
      t  = m_cyc + 1;
      mr = bus.ModeBtn && !m_mprev && m_mlow;
      ur = bus.UpBtn && !m_uprev && m_ulow;
      ed = (m_state != 0);
      pv = m_pvalid;
      tp = m_tpress;
      if (mr || !bus.UpBtn || !ed) pv = 0;
      else if (ur) begin pv = 1; tp = t; end
      strobe = 0;
      if (pv) begin
        d = t - tp;
        strobe = (d == 0) || (d >= RD && ((d - RD) % RP) == 0);
      end
      ns = m_state; tc = m_tchange; la = m_lastact;
      if (mr) begin ns = (m_state + 1) % 5; tc = t; la = t; end
      else if (ed && bus.UpBtn) la = t;
      else if (ed && (t - la) >= TO) begin ns = 0; tc = t; end
      ph = (((t - tc) / BH) % 2) == 1;
      exp_min   <= strobe && (m_state == 2 || m_state == 4);
      exp_hour  <= strobe && (m_state == 1 || m_state == 3);
      exp_state <= ns;
      exp_alm   <= (ns == 3 || ns == 4);
      exp_hold  <= (ns == 1 || ns == 2);
      exp_mask  <= (ph && !bus.UpBtn) ? ((ns == 1 || ns == 3) ? 12 : (ns == 2 || ns == 4) ? 3 : 0) : 0;
      m_cyc <= t; m_state <= ns; m_tpress <= tp; m_tchange <= tc; m_lastact <= la;
      m_pvalid <= pv;
      m_mprev <= bus.ModeBtn; m_uprev <= bus.UpBtn;
      m_mlow <= m_mlow || !bus.ModeBtn; m_ulow <= m_ulow || !bus.UpBtn;
    end
  end

  always @(negedge clk) begin
    check("cmp_EditState", int'(bus.EditState), exp_state);
    check("cmp_MinInc",    int'(bus.MinInc),    int'(exp_min));
    check("cmp_HourInc",   int'(bus.HourInc),   int'(exp_hour));
    check("cmp_AlarmSel",  int'(bus.AlarmSel),  int'(exp_alm));
    check("cmp_ClockHold", int'(bus.ClockHold), int'(exp_hold));
    check("cmp_BlinkMask", int'(bus.BlinkMask), exp_mask);
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_count(input int n, output int h, output int m);
    h = 0; m = 0;
    repeat (n) begin
      @(negedge clk);
      h += int'(bus.HourInc);
      m += int'(bus.MinInc);
    end
  endtask

  task automatic mode_pulse();
    bus.ModeBtn = 1'b1; run(3);
    bus.ModeBtn = 1'b0; run(3);
  endtask

  int seq_state[5] = '{1, 2, 3, 4, 0};
  int h, m, want_mask;

  initial begin
    bus.ModeBtn = 1'b1;
    bus.UpBtn   = 1'b1;

    // Reset with both buttons held
    run(3);
    check("rst_EditState", int'(bus.EditState), 0);
    check("rst_BlinkMask", int'(bus.BlinkMask), 0);
    check("rst_Strobes", int'(bus.MinInc) + int'(bus.HourInc), 0);
    check("rst_AlarmHold", int'(bus.AlarmSel) + int'(bus.ClockHold), 0);
    CLR = 1'b0;
    run_count(6, h, m);
    check("rel_strobes", h + m, 0);
    check("rel_state", int'(bus.EditState), 0);
    $display("T1 reset release with buttons held: state=%0d strobes=%0d", bus.EditState, h + m);
    bus.ModeBtn = 1'b0;
    bus.UpBtn   = 1'b0;
    run(3);

    // Five MODE presses walk the ring
    for (int i = 0; i < 5; i++) begin
      mode_pulse();
      check("seq_EditState", int'(bus.EditState), seq_state[i]);
      check("seq_ClockHold", int'(bus.ClockHold), int'(seq_state[i] == 1 || seq_state[i] == 2));
      check("seq_AlarmSel", int'(bus.AlarmSel), int'(seq_state[i] == 3 || seq_state[i] == 4));
      $display("T2 mode press %0d: state=%0d hold=%0d alm=%0d", i, bus.EditState, bus.ClockHold, bus.AlarmSel);
    end

    // SET_MIN with UP held for 20 cycles
    mode_pulse();
    mode_pulse();
    check("setmin_state", int'(bus.EditState), 2);
    bus.UpBtn = 1'b1;
    m = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      check("rep_MinInc", int'(bus.MinInc), int'(j == 1 || j == 9 || j == 13 || j == 17));
      check("rep_HourInc", int'(bus.HourInc), 0);
      check("rep_BlinkMask", int'(bus.BlinkMask), 0);
      m += int'(bus.MinInc);
    end
    bus.UpBtn = 1'b0;
    check("rep_count", m, 4);
    $display("T3 UP held 20 cycles in SET_MIN: MinInc strobes=%0d", m);
    run(40);
    check("setmin_timeout", int'(bus.EditState), 0);

    // UP ignored in RUN; simultaneous MODE+UP
    bus.UpBtn = 1'b1; run_count(2, h, m);
    bus.UpBtn = 1'b0; run(2);
    check("run_up_ignored", h + m, 0);
    bus.ModeBtn = 1'b1;
    bus.UpBtn   = 1'b1;
    @(negedge clk);
    check("simul_state", int'(bus.EditState), 1);
    check("simul_HourInc", int'(bus.HourInc), 0);
    run_count(2, h, m);
    bus.ModeBtn = 1'b0;
    begin
      int h2, m2;
      run_count(17, h2, m2);
      h += h2; m += m2;
    end
    check("simul_no_repeat", h + m, 0);
    check("simul_state_kept", int'(bus.EditState), 1);
    bus.UpBtn = 1'b0;
    $display("T4 MODE+UP together: state=%0d strobes=%0d", bus.EditState, h + m);
    run(2);

    // ALM_HR idle timeout and blink pattern
    mode_pulse();
    check("pre_alm_state", int'(bus.EditState), 2);
    bus.ModeBtn = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      want_mask = (k <= 32 && (((k - 1) / 4) % 2) == 1) ? 12 : 0;
      check("to_EditState", int'(bus.EditState), (k <= 32) ? 3 : 0);
      check("to_AlarmSel", int'(bus.AlarmSel), int'(k <= 32));
      check("to_BlinkMask", int'(bus.BlinkMask), want_mask);
      if (k == 3) bus.ModeBtn = 1'b0;
    end
    $display("T5 ALM_HR idle timeout: state=%0d alm=%0d", bus.EditState, bus.AlarmSel);

    // CLR during auto-repeat in SET_HR
    mode_pulse();
    check("clr_pre_state", int'(bus.EditState), 1);
    bus.UpBtn = 1'b1;
    run_count(13, h, m);
    check("clr_pre_hour", h, 3);
    check("clr_pre_min", m, 0);
    #2 CLR = 1'b1;
    #1;
    check("clr_EditState", int'(bus.EditState), 0);
    check("clr_HourInc", int'(bus.HourInc), 0);
    check("clr_outputs", int'(bus.MinInc) + int'(bus.AlarmSel) + int'(bus.ClockHold) + int'(bus.BlinkMask), 0);
    repeat (2) @(negedge clk);
    CLR = 1'b0;
    run_count(12, h, m);
    check("clr_post_strobes", h + m, 0);
    check("clr_post_state", int'(bus.EditState), 0);
    bus.UpBtn = 1'b0;
    $display("T6 CLR mid-repeat: state=%0d strobes after release=%0d", bus.EditState, h + m);
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
